// File: rtl/alu_pipe.sv
// Pipelined Hack-style ALU with valid/ready handshakes and carry/overflow flags.
// Define ALU_MUL_EN to build in the iterative shift-add multiplier.
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   input  logic             mul,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy,
   output logic             ov
);

   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_next;

   logic [WIDTH-1:0] xz, xp, yz, yp;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_r, alu_res;
   logic             alu_cy, alu_ov;

   assign xz = zx ? '0 : x;
   assign xp = nx ? ~xz : xz;
   assign yz = zy ? '0 : y;
   assign yp = ny ? ~yz : yz;

   // Flags come from the raw sum, before the optional output inversion.
   assign sum     = {1'b0, xp} + {1'b0, yp};
   assign alu_r   = f ? sum[WIDTH-1:0] : (xp & yp);
   assign alu_res = no ? ~alu_r : alu_r;
   assign alu_cy  = f & sum[WIDTH];
   assign alu_ov  = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);

   logic             out_free;
   logic             load;
   logic             mul_start;
   logic [WIDTH-1:0] load_out;
   logic             load_cy, load_ov;

   assign out_free = !out_valid || out_ready;

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand, acc;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               mul_no;
   logic               mul_done;

   assign mul_done = (cnt == CW'(WIDTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         mul_no <= 1'b0;
      end else if (mul_start) begin
         mcand  <= {{WIDTH{1'b0}}, xp};
         mplier <= yp;
         acc    <= '0;
         cnt    <= '0;
         mul_no <= no;
      end else if (state == MUL && !mul_done) begin
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end
`else
   logic mul_unused;
   assign mul_unused = mul;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      load       = 1'b0;
      mul_start  = 1'b0;
      load_out   = alu_res;
      load_cy    = alu_cy;
      load_ov    = alu_ov;
      case (state)
         IDLE: begin
            in_ready = !reset && out_free;
            if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
               if (mul) begin
                  mul_start  = 1'b1;
                  state_next = MUL;
               end else begin
                  load = 1'b1;
               end
`else
               load = 1'b1;
`endif
            end
         end
         MUL: begin
`ifdef ALU_MUL_EN
            // Finished product waits here, frozen, until the result register frees.
            if (mul_done && out_free) begin
               load       = 1'b1;
               load_out   = mul_no ? ~acc[WIDTH-1:0] : acc[WIDTH-1:0];
               load_cy    = 1'b0;
               load_ov    = |acc[2*WIDTH-1:WIDTH];
               state_next = IDLE;
            end
`else
            state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // zr/ng are registered so that every output reads 0 out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out       <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
         cy        <= 1'b0;
         ov        <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out       <= load_out;
         zr        <= (load_out == '0);
         ng        <= load_out[WIDTH-1];
         cy        <= load_cy;
         ov        <= load_ov;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
